// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register file write port among NUM_REQ requesters.
// Define WB_PORT_ARBITER_CLEAR_EN to zero x1..x(NO_OF_REGS-1) after every reset.
module wb_port_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int REG_SIZE   = 32,
    parameter int NO_OF_REGS = 32,
    parameter int REGW       = $clog2(NO_OF_REGS)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    input  logic [NUM_REQ*REGW-1:0]      req_addr_i,
    input  logic [NUM_REQ*REG_SIZE-1:0]  req_data_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    output logic                         we_o,
    output logic [REGW-1:0]              waddr_o,
    output logic [REG_SIZE-1:0]          wdata_o,
    output logic                         busy_o
);

    localparam int IDXW = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_REQ - 1);

    logic [REGW-1:0]     addr_a [NUM_REQ];
    logic [REG_SIZE-1:0] data_a [NUM_REQ];

    logic                we_q, we_d;
    logic [REGW-1:0]     waddr_q, waddr_d;
    logic [REG_SIZE-1:0] wdata_q, wdata_d;
    logic [IDXW-1:0]     ptr_q, ptr_d;
    logic [IDXW-1:0]     gnt_idx;
    logic                gnt_any;
    logic                arb_on;
    logic                take;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign addr_a[k] = req_addr_i[k*REGW +: REGW];
        assign data_a[k] = req_data_i[k*REG_SIZE +: REG_SIZE];
    end

`ifdef WB_PORT_ARBITER_CLEAR_EN
    typedef enum logic {
        CLEAR,
        ARB
    } state_t;

    localparam logic [REGW-1:0] LAST_REG = REGW'(NO_OF_REGS - 1);

    state_t          state_q, state_d;
    logic [REGW-1:0] cnt_q, cnt_d;

    assign arb_on = (state_q == ARB);
    assign busy_o = (state_q == CLEAR);
`else
    assign arb_on = 1'b1;
    assign busy_o = 1'b0;
`endif

    function automatic logic [IDXW-1:0] rr_idx(
        input logic [IDXW-1:0] base,
        input int              off
    );
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s[IDXW-1:0];
    endfunction

    // Walk offsets downward so the nearest valid requester above ptr wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            if (req_valid_i[rr_idx(ptr_q, off)]) begin
                gnt_any = 1'b1;
                gnt_idx = rr_idx(ptr_q, off);
            end
        end
    end

    assign take        = arb_on && gnt_any && !rst_i;
    assign req_ready_o = take ? (ONE << gnt_idx) : '0;

    always_comb begin
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        ptr_d   = ptr_q;
`ifdef WB_PORT_ARBITER_CLEAR_EN
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            we_d    = 1'b1;
            waddr_d = cnt_q;
            wdata_d = '0;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_REG) state_d = ARB;
        end else
`endif
        if (take) begin
            // x0 is hardwired to zero, so its writes are granted but dropped.
            we_d    = (addr_a[gnt_idx] != '0);
            waddr_d = addr_a[gnt_idx];
            wdata_d = data_a[gnt_idx];
            ptr_d   = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            ptr_q   <= '0;
`ifdef WB_PORT_ARBITER_CLEAR_EN
            state_q <= CLEAR;
            cnt_q   <= REGW'(1);
`endif
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            ptr_q   <= ptr_d;
`ifdef WB_PORT_ARBITER_CLEAR_EN
            state_q <= state_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign we_o    = we_q;
    assign waddr_o = waddr_q;
    assign wdata_o = wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized bench for wb_port_arbiter against a cycle-level reference model.
// Honours WB_PORT_ARBITER_CLEAR_EN to expect the post-reset zero sweep.
module tb_wb_port_arbiter;

    localparam int N  = 3;
    localparam int W  = 32;
    localparam int R  = 32;
    localparam int AW = 5;
`ifdef WB_PORT_ARBITER_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*W-1:0]  req_data = '0;
    logic [N-1:0]  req_ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [W-1:0]  wdata;
    logic          busy;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .NUM_REQ(N),
        .REG_SIZE(W),
        .NO_OF_REGS(R)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .req_valid_i(req_valid),
        .req_addr_i(req_addr),
        .req_data_i(req_data),
        .req_ready_o(req_ready),
        .we_o(we),
        .waddr_o(waddr),
        .wdata_o(wdata),
        .busy_o(busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Requester protocol: valid may only fall after it was accepted.
    logic [N-1:0] hold_q = '0;
    always @(posedge clk) hold_q <= rst ? '0 : (req_valid & ~req_ready);
    always @(negedge clk)
        assert ((hold_q & ~req_valid) == '0)
        else $error("protocol: valid dropped before accept");

    int          m_ptr = 0;
    bit          m_busy = CLR;
    int          m_cnt = 1;
    bit          m_we = 1'b0;
    int          m_addr = 0;
    logic [W-1:0] m_data = '0;
    bit          m_known = 1'b1;
    int          waits [N];

    function automatic int pick();
        if (rst || m_busy) return -1;
        for (int i = 0; i < N; i++) begin
            int k = (m_ptr + i) % N;
            if (req_valid[k]) return k;
        end
        return -1;
    endfunction

    task automatic set_req(input int k, input int a, input logic [W-1:0] d);
        req_valid[k] = 1'b1;
        req_addr[k*AW +: AW] = AW'(a);
        req_data[k*W +: W] = d;
    endtask

    task automatic step();
        int g;
        int dg;
        bit r;
        logic [N-1:0] er;
        logic [AW-1:0] ga;
        @(negedge clk);
        g = pick();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        check("ready", req_ready, er);
        dg = -1;
        for (int k = 0; k < N; k++) if (req_ready[k]) dg = k;
        if (dg >= 0) begin
            for (int k = 0; k < N; k++) begin
                if (k == dg) begin
                    check("fair", waits[k] < N, 1'b1);
                    waits[k] = 0;
                end else if (req_valid[k]) begin
                    waits[k]++;
                end
            end
        end
        @(posedge clk);
        r = rst;
        if (r) begin
            m_ptr = 0; m_we = 0; m_addr = 0; m_data = '0;
            m_busy = CLR; m_cnt = 1; m_known = 1;
            for (int k = 0; k < N; k++) waits[k] = 0;
        end else if (m_busy) begin
            m_we = 1; m_addr = m_cnt; m_data = '0; m_known = 1;
            if (m_cnt == R - 1) m_busy = 0;
            m_cnt++;
        end else if (g >= 0) begin
            ga = req_addr[g*AW +: AW];
            m_we = (ga != 0);
            m_known = m_we;
            m_addr = int'(ga);
            m_data = req_data[g*W +: W];
            m_ptr = (g + 1) % N;
        end else begin
            m_we = 0;
        end
        #1;
        check("we", we, m_we);
        check("busy", busy, m_busy);
        if (m_known) begin
            check("waddr", waddr, m_addr);
            check("wdata", wdata, m_data);
        end
        if (r) req_valid = '0;
        else if (g >= 0) req_valid[g] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (req_valid != '0 && n < 80) begin
            step();
            n++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (CLR ? R - 1 : 0) step();
    endtask

    initial begin
        for (int k = 0; k < N; k++) waits[k] = 0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        set_req(0, 3, 32'h77);
        repeat (CLR ? R + 2 : 3) step();

        do_reset();
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < N; k++)
                if (!req_valid[k]) set_req(k, 5 + k, 32'hA + k);
            step();
        end
        drain();

        set_req(0, 4, 32'h1111);
        step();
        set_req(2, 8, 32'h2222);
        step();
        set_req(0, 10, 32'h3333);
        set_req(1, 11, 32'h4444);
        drain();

        set_req(0, 12, 32'h5555);
        step();
        set_req(1, 0, 32'hDEAD);
        step();
        set_req(1, 13, 32'h6666);
        set_req(2, 14, 32'h7777);
        drain();

        set_req(2, 9, 32'h55);
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_req(0, 15, 32'h8888);
        set_req(1, 16, 32'h9999);
        repeat (CLR ? R - 1 : 0) step();
        drain();

        for (int i = 0; i < 500; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int k = 0; k < N; k++)
                if (!req_valid[k] && $urandom_range(0, 1) == 1)
                    set_req(k, $urandom_range(0, R - 1), $urandom);
            step();
        end
        rst = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Write-back port arbiter and initialization sequencer for the processor's register file. It shares the register file's single write port (`we`, `waddr_i`, `wdata_i`) among `NUM_REQ` write-back requesters, such as the ALU, load unit and CSR unit, using round-robin arbitration with a valid/ready handshake. Write-back commands reach the register file through a registered output stage. Optionally, after every reset the block walks the register file and writes zero to every register except x0 before it accepts any requests.

## Interface
- `NUM_REQ`, default 3: number of write-back requesters (minimum 2).
- `REG_SIZE`, default 32: data width.
- `NO_OF_REGS`, default 32: number of architectural registers.
- `REGW`, default `$clog2(NO_OF_REGS)`: register address width.

Ports:
- `clk_i` in 1: clock. All state updates on posedge.
- `rst_i` in 1: reset. Synchronous, active-high.
- `req_valid_i` in `NUM_REQ`: bit k means requester k has a write pending.
- `req_addr_i` in `NUM_REQ*REGW`: destination register. Requester k uses slice `[k*REGW +: REGW]`.
- `req_data_i` in `NUM_REQ*REG_SIZE`: write data. Requester k uses slice `[k*REG_SIZE +: REG_SIZE]`.
- `req_ready_o` out `NUM_REQ`: one-hot or zero grant. A transfer happens for requester k when valid[k] and ready[k] are both high at a posedge.
- `we_o` out 1: write enable to the register file `we`.
- `waddr_o` out `REGW`: write address to the register file.
- `wdata_o` out `REG_SIZE`: write data to the register file.
- `busy_o` out 1: high while the initialization sweep is running.

## Operation
- States: CLEAR and ARB. CLEAR exists only when `WB_PORT_ARBITER_CLEAR_EN` is defined.
- Values at reset:
  - `we_o`=0, `waddr_o`=0, `wdata_o`=0, `req_ready_o`=0.
  - Round-robin pointer=0, clear counter=1.
  - State=CLEAR and `busy_o`=1 when the macro is defined; state=ARB and `busy_o`=0 otherwise.
- CLEAR state:
  - Each cycle registers `we_o`=1, `waddr_o`=counter, `wdata_o`=0, then increments the counter.
  - On the edge that registers address `NO_OF_REGS-1`, the state moves to ARB and `busy_o` goes to 0.
  - `req_ready_o` is 0 throughout.
- ARB state:
  - `req_ready_o` is combinational. It is one-hot on the first valid requester found by searching from the pointer upward, wrapping modulo `NUM_REQ`. It is all zero when no requester is valid.
  - On a transfer from requester k, the registered outputs take `we_o`=1, `waddr_o`=addr[k], `wdata_o`=data[k], and the pointer becomes `(k+1) mod NUM_REQ`.
  - With no transfer, `we_o` is 0, `waddr_o`/`wdata_o` hold their last values, and the pointer is unchanged.
- Writes to x0: a request with addr=0 is still granted and the pointer still advances. The write is dropped: `we_o`=0.
- Requester obligation: once valid is high, valid, addr and data stay stable until accepted. Dropping valid before acceptance is a protocol violation; the bench asserts on it.
- Fairness: a requester that stays valid is granted within `NUM_REQ` grant cycles.
- Reset mid-operation: any in-flight registered write is cancelled (`we_o`=0 after the edge). No pending request is remembered. The pointer returns to 0, and CLEAR restarts from address 1 if enabled.

## Timing
- Grant-to-write latency: 1 cycle. A transfer at posedge N puts `we_o`/`waddr_o`/`wdata_o` on the outputs from posedge N until posedge N+1. The register file commits the write on the negedge within that cycle.
- Throughput: one write per cycle, with back-to-back grants allowed, including repeated grants to the same requester when it is the only one valid.
- Clear sweep: `NO_OF_REGS-1` cycles. The first clear write appears on the first posedge with `rst_i` low. The first request grant is possible in the cycle after the last clear write is registered.
- Simultaneous reset and valid: reset wins; no grant.

## Configuration
- `WB_PORT_ARBITER_CLEAR_EN` defined:
  - The CLEAR state and counter are compiled in.
  - Every reset is followed by the zero sweep of registers 1..`NO_OF_REGS-1`.
- Macro undefined:
  - No counter and no CLEAR state; `busy_o` is tied to 0.
  - ARB starts on the first posedge after reset, so preloaded register contents survive reset.

## Test plan
- Clear sweep (macro defined, `NO_OF_REGS`=32): release reset, no requests. Expect `we_o`=1 with `waddr_o`=1..31 and `wdata_o`=0 on 31 consecutive cycles. `busy_o` then falls, and `req_ready_o` stays 0 throughout the sweep.
- Round-robin: requesters 0, 1 and 2 all valid continuously, addresses 5/6/7, data 0xA/0xB/0xC. Expect grant order 0,1,2,0,1,2. Writes (5,0xA), (6,0xB), (7,0xC) appear one cycle after each grant.
- Pointer skip: only requester 2 valid after a grant to requester 0. Expect requester 2 granted immediately. A following simultaneous request from 0 and 1 grants 0 first.
- x0 drop: requester 1 sends addr=0, data=0xDEAD. Expect ready[1]=1 for one cycle, `we_o` stays 0, and the pointer advances to 2.
- Mid-operation reset: assert `rst_i` for one cycle in the same cycle as a grant to (addr 9, 0x55). Expect `we_o`=0 next cycle, no write to x9, `busy_o`=1, and the sweep restarting at `waddr_o`=1.
- Macro undefined: release reset with requester 0 valid (addr 3, 0x77). Expect a grant on the first cycle and `we_o`/`waddr_o`=3/`wdata_o`=0x77 one cycle later. `busy_o` is never 1.
